floor_request_ctrl: RTL

- Command stage directly upstream of the 4-bit Counter in the elevator datapath.
- The Counter holds the current floor.
- This block queues floor requests, drives the Counter's enb/modo/data to step the car up or down one floor at a time, watches Q to stop at the target, and then holds the door open for a fixed time.

---
 rtl/floor_request_ctrl_pkg.sv | 16 +
 rtl/floor_request_ctrl_req_fifo.sv | 38 +++
 rtl/floor_request_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/floor_request_ctrl_pkg.sv
// floor_request_ctrl_pkg: shared Counter modes, floor width and controller state encoding
package floor_request_ctrl_pkg;
    localparam int FLOOR_W = 4;
    localparam logic [1:0] MODO_UP = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_LOAD = 2'b11;
    typedef enum logic [2:0] {
        INIT,
        INIT_WAIT,
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        SETTLE,
        DOOR
    } state_t;
endpackage

// File: rtl/floor_request_ctrl_req_fifo.sv
// req_fifo: small synchronous request queue with a combinationally visible head
module req_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr - rd_ptr) == (AW + 1)'(DEPTH);
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rd_ptr[AW-1:0]];
    // storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
    // read and write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/floor_request_ctrl.sv
// floor_request_ctrl: queues floor requests and steps the floor Counter one floor at a time
module floor_request_ctrl
    import floor_request_ctrl_pkg::*;
#(
    parameter int MAX_FLOOR = 15,
    parameter int DOOR_CYCLES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    input  logic [FLOOR_W-1:0] cnt_Q,
    output logic               cnt_enb,
    output logic [1:0]         cnt_modo,
    output logic [FLOOR_W-1:0] cnt_data,
    output logic               door_open,
    output logic               busy,
    output logic               err
);
    localparam int DW = DOOR_CYCLES > 1 ? $clog2(DOOR_CYCLES) : 1;
    state_t state, next;
    logic [FLOOR_W-1:0] target, head;
    logic [DW-1:0] door_cnt;
    logic full, empty, accept, in_range, pop;
    assign in_range = req_floor <= FLOOR_W'(MAX_FLOOR);
    assign req_ready = ~full & (state != INIT) & (state != INIT_WAIT);
    assign accept = req_valid & req_ready;
    assign pop = (state == IDLE) & ~empty;
    assign busy = (state != IDLE) | ~empty;
    assign door_open = state == DOOR;
    assign cnt_data = '0;
    // rst also gates the Counter drive so the held-in-reset INIT state never commands the Counter
    assign cnt_enb = ~rst & ((state == INIT) | (state == MOVE_UP) | (state == MOVE_DOWN));
    assign cnt_modo = rst ? MODO_UP : (state == INIT) ? MODO_LOAD : (state == MOVE_DOWN) ? MODO_DOWN : MODO_UP;
    req_fifo #(.WIDTH(FLOOR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept & in_range),
        .pop   (pop),
        .din   (req_floor),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // next-state: step toward the target, settle one cycle so cnt_Q is fresh, then hold the door
    always_comb begin
        next = state;
        case (state)
            INIT:              next = INIT_WAIT;
            INIT_WAIT:         next = IDLE;
            IDLE:              if (!empty) next = (head > cnt_Q) ? MOVE_UP : (head < cnt_Q) ? MOVE_DOWN : DOOR;
            MOVE_UP, MOVE_DOWN: next = SETTLE;
            SETTLE:            next = (cnt_Q == target) ? DOOR : (cnt_Q < target) ? MOVE_UP : MOVE_DOWN;
            DOOR:              if (door_cnt == '0) next = IDLE;
            default:           next = INIT;
        endcase
    end
    // state register, latched target, door down-counter and the dropped-request error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            target <= '0;
            door_cnt <= '0;
            err <= 1'b0;
        end else begin
            state <= next;
            err <= accept & ~in_range;
            if (pop) target <= head;
            if (next == DOOR && state != DOOR) door_cnt <= DW'(DOOR_CYCLES - 1);
            else if (state == DOOR) door_cnt <= door_cnt - 1'b1;
        end
    end
endmodule
